// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - coin encodings, coin values and FSM state type shared by the vending machine
package vm_pkg;

   typedef enum logic [1:0] {
      COIN_NONE = 2'b00,
      COIN_5    = 2'b01,
      COIN_10   = 2'b10,
      COIN_25   = 2'b11
   } coin_e;

   localparam int COIN_VAL_5  = 5;
   localparam int COIN_VAL_10 = 10;
   localparam int COIN_VAL_25 = 25;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_VEND    = 2'd2
   } vm_state_e;

endpackage

// File: rtl/vm_coin_decode.sv
// rtl/vm_coin_decode.sv - combinational coin code to credit value decoder
module vm_coin_decode
   import vm_pkg::*;
#(
   parameter int CREDIT_W = 8
) (
   input  logic [1:0]          coin_code,
   output logic [CREDIT_W-1:0] coin_value
);

   always_comb begin
      coin_value = '0;
      case (coin_e'(coin_code))
         COIN_5:  coin_value = CREDIT_W'(COIN_VAL_5);
         COIN_10: coin_value = CREDIT_W'(COIN_VAL_10);
         COIN_25: coin_value = CREDIT_W'(COIN_VAL_25);
         default: coin_value = '0;
      endcase
   end

endmodule

// File: rtl/multi_item_vm.sv
// rtl/multi_item_vm.sv - multi-item vending machine; VM_STOCK_EN adds per-item stock and restock
module multi_item_vm
   import vm_pkg::*;
#(
   parameter int                            NUM_ITEMS  = 4,
   parameter int                            CREDIT_W   = 8,
   parameter int                            MAX_CREDIT = 50,
   parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd10}
`ifdef VM_STOCK_EN
   ,
   parameter int                            STOCK_INIT = 3
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           sel,
   input  logic                 sel_vld,
   input  logic [1:0]           coin,
   input  logic                 cancel,
   output logic                 dispense,
   output logic [3:0]           item,
   output logic [CREDIT_W-1:0]  change,
   output logic                 change_vld,
   output logic [CREDIT_W-1:0]  credit,
   output logic                 coin_reject
`ifdef VM_STOCK_EN
   ,
   input  logic                 restock,
   output logic [NUM_ITEMS-1:0] sold_out
`endif
);

   localparam logic [3:0]        NUM_ITEMS_L = 4'(NUM_ITEMS);
   localparam logic [CREDIT_W:0] MAX_L       = (CREDIT_W+1)'(MAX_CREDIT);

   vm_state_e           state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] change_q, change_d;
   logic [3:0]          latch_q, latch_d;
   logic [3:0]          item_q, item_d;
   logic                dispense_q, dispense_d;
   logic                change_vld_q, change_vld_d;
   logic                coin_reject_q, coin_reject_d;

   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W-1:0] price;
   logic [CREDIT_W-1:0] new_credit;
   logic [CREDIT_W:0]   sum;
   logic [3:0]          next_item;
   logic                coin_ok;
   logic                sel_ok;
   logic                sold;
   logic                vend;

   vm_coin_decode #(.CREDIT_W(CREDIT_W)) u_coin_decode (
      .coin_code  (coin),
      .coin_value (coin_val)
   );

`ifdef VM_STOCK_EN
   localparam int STOCK_W = $clog2(STOCK_INIT + 1);
   logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
   logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

   always_comb begin
      sold = 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         sold_out[i] = (stock_q[i] == '0);
         if (sel == 4'(i + 1) && stock_q[i] == '0) sold = 1'b1;
      end
   end

   // Restock wins over a vend decrement landing on the same edge.
   always_comb begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
         stock_d[i] = stock_q[i];
         if (restock) stock_d[i] = STOCK_W'(STOCK_INIT);
         else if (vend && next_item == 4'(i + 1) && stock_q[i] != '0) stock_d[i] = stock_q[i] - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (!reset) stock_q[i] <= STOCK_W'(STOCK_INIT);
         else        stock_q[i] <= stock_d[i];
      end
   end
`else
   assign sold = 1'b0;
`endif

   always_comb begin
      sel_ok    = sel_vld && (sel != 4'd0) && (sel <= NUM_ITEMS_L) && !sold;
      next_item = (state_q != ST_VEND && sel_ok) ? sel : latch_q;
      sum       = {1'b0, credit_q} + {1'b0, coin_val};
      coin_ok   = (coin != 2'b00) && (sum <= MAX_L);
   end

   always_comb begin
      price = '0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
         if (next_item == 4'(i + 1)) price = PRICES[i*CREDIT_W +: CREDIT_W];
      end
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      latch_d       = latch_q;
      dispense_d    = 1'b0;
      item_d        = 4'd0;
      change_d      = '0;
      change_vld_d  = 1'b0;
      coin_reject_d = 1'b0;
      new_credit    = credit_q;
      vend          = 1'b0;
      case (state_q)
         ST_VEND: begin
            coin_reject_d = (coin != 2'b00);
            latch_d       = 4'd0;
            state_d       = ST_IDLE;
         end
         default: begin
            if (cancel) begin
               coin_reject_d = (coin != 2'b00);
               if (credit_q != '0) begin
                  change_vld_d = 1'b1;
                  change_d     = credit_q;
               end
               credit_d = '0;
               latch_d  = 4'd0;
               state_d  = ST_IDLE;
            end else begin
               coin_reject_d = (coin != 2'b00) && !coin_ok;
               new_credit    = coin_ok ? sum[CREDIT_W-1:0] : credit_q;
               latch_d       = next_item;
               if (next_item != 4'd0 && new_credit >= price) begin
                  vend         = 1'b1;
                  dispense_d   = 1'b1;
                  item_d       = next_item;
                  change_d     = new_credit - price;
                  change_vld_d = 1'b1;
                  credit_d     = '0;
                  latch_d      = 4'd0;
                  state_d      = ST_VEND;
               end else begin
                  credit_d = new_credit;
                  state_d  = (next_item != 4'd0) ? ST_COLLECT : ST_IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         credit_q      <= '0;
         latch_q       <= 4'd0;
         dispense_q    <= 1'b0;
         item_q        <= 4'd0;
         change_q      <= '0;
         change_vld_q  <= 1'b0;
         coin_reject_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         latch_q       <= latch_d;
         dispense_q    <= dispense_d;
         item_q        <= item_d;
         change_q      <= change_d;
         change_vld_q  <= change_vld_d;
         coin_reject_q <= coin_reject_d;
      end
   end

   assign dispense    = dispense_q;
   assign item        = item_q;
   assign change      = change_q;
   assign change_vld  = change_vld_q;
   assign credit      = credit_q;
   assign coin_reject = coin_reject_q;

endmodule

// File: tb/tb_multi_item_vm.sv
// tb/tb_multi_item_vm.sv - self-checking bench for multi_item_vm with an integer transaction model
module tb_multi_item_vm;

   localparam int N    = 4;
   localparam int MAXC = 50;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] sel;
   logic       sel_vld;
   logic [1:0] coin;
   logic       cancel;
   logic       dispense;
   logic [3:0] item;
   logic [7:0] change;
   logic       change_vld;
   logic [7:0] credit;
   logic       coin_reject;
`ifdef VM_STOCK_EN
   logic       restock;
   logic [3:0] sold_out;
   int         m_stock [4];
   logic [3:0] n_sold, e_sold;
`endif

   int total = 0;
   int bad   = 0;
   bit armed = 0;

   int m_credit, m_sel;
   bit m_vend;
   int n_disp, n_item, n_chg, n_cv, n_rej, n_credit;
   int e_disp, e_item, e_chg, e_cv, e_rej, e_credit;

   multi_item_vm dut (
      .clk         (clk),
      .reset       (reset),
      .sel         (sel),
      .sel_vld     (sel_vld),
      .coin        (coin),
      .cancel      (cancel),
      .dispense    (dispense),
      .item        (item),
      .change      (change),
      .change_vld  (change_vld),
      .credit      (credit),
      .coin_reject (coin_reject)
`ifdef VM_STOCK_EN
      ,
      .restock     (restock),
      .sold_out    (sold_out)
`endif
   );

   always #5 clk = ~clk;

   function automatic int price_of(int i);
      case (i)
         1: return 10;
         2: return 15;
         3: return 20;
         4: return 25;
         default: return 0;
      endcase
   endfunction

   function automatic int coin_value(int c);
      case (c)
         1: return 5;
         2: return 10;
         3: return 25;
         default: return 0;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Next-cycle outputs follow from the transaction rules applied to this cycle's inputs.
   task automatic model_step();
      int v, s;
      bit sold;
      n_disp = 0; n_item = 0; n_chg = 0; n_cv = 0; n_rej = 0;
      v = coin_value(int'(coin));
      s = int'(sel);
      sold = 0;
`ifdef VM_STOCK_EN
      if (s >= 1 && s <= N) sold = (m_stock[s-1] == 0);
`endif
      if (!reset) begin
         m_credit = 0; m_sel = 0; m_vend = 0;
`ifdef VM_STOCK_EN
         for (int i = 0; i < N; i++) m_stock[i] = 3;
`endif
      end else begin
         if (m_vend) begin
            n_rej  = (v != 0);
            m_vend = 0;
         end else if (cancel) begin
            n_rej = (v != 0);
            if (m_credit > 0) begin
               n_cv  = 1;
               n_chg = m_credit;
            end
            m_credit = 0;
            m_sel    = 0;
         end else begin
            if (v != 0) begin
               if (m_credit + v > MAXC) n_rej = 1;
               else m_credit += v;
            end
            if (sel_vld && s >= 1 && s <= N && !sold) m_sel = s;
            if (m_sel != 0 && m_credit >= price_of(m_sel)) begin
               n_disp = 1;
               n_item = m_sel;
               n_chg  = m_credit - price_of(m_sel);
               n_cv   = 1;
`ifdef VM_STOCK_EN
               if (m_stock[m_sel-1] > 0) m_stock[m_sel-1]--;
`endif
               m_credit = 0;
               m_sel    = 0;
               m_vend   = 1;
            end
         end
`ifdef VM_STOCK_EN
         if (restock) for (int i = 0; i < N; i++) m_stock[i] = 3;
`endif
      end
      n_credit = m_credit;
`ifdef VM_STOCK_EN
      for (int i = 0; i < N; i++) n_sold[i] = (m_stock[i] == 0);
`endif
   endtask

   task automatic step(input bit v, input int s, input int c, input bit cn, input bit rn);
      sel_vld = v;
      sel     = 4'(s);
      coin    = 2'(c);
      cancel  = cn;
      reset   = rn;
      model_step();
      @(posedge clk);
      #1;
      e_disp = n_disp; e_item = n_item; e_chg = n_chg; e_cv = n_cv; e_rej = n_rej; e_credit = n_credit;
`ifdef VM_STOCK_EN
      e_sold = n_sold;
`endif
   endtask

   always @(negedge clk) begin
      if (armed) begin
         chk("dispense", dispense, e_disp);
         chk("item", item, e_item);
         chk("change", change, e_chg);
         chk("change_vld", change_vld, e_cv);
         chk("credit", credit, e_credit);
         chk("coin_reject", coin_reject, e_rej);
`ifdef VM_STOCK_EN
         chk("sold_out", sold_out, e_sold);
`endif
      end
   end

   initial begin
`ifdef VM_STOCK_EN
      restock = 1'b0;
`endif
      step(0, 0, 0, 0, 0);
      armed = 1;
      step(0, 0, 0, 0, 0);
      chk("rst_credit", credit, 0);
      chk("rst_disp", dispense, 0);
      chk("rst_cv", change_vld, 0);

      step(1, 1, 0, 0, 1);
      step(0, 0, 2, 0, 1);
      chk("t1_disp", dispense, 1);
      chk("t1_item", item, 1);
      chk("t1_chg", change, 0);
      chk("t1_cv", change_vld, 1);
      step(0, 0, 0, 0, 1);
      chk("t1_after", dispense, 0);

      step(1, 2, 0, 0, 1);
      step(0, 0, 1, 0, 1);
      chk("t2_credit5", credit, 5);
      step(0, 0, 3, 0, 1);
      chk("t2_item", item, 2);
      chk("t2_chg", change, 15);
      step(0, 0, 0, 0, 1);

      step(0, 0, 3, 0, 1);
      step(0, 0, 3, 0, 1);
      chk("t3_credit", credit, 50);
      step(0, 0, 1, 0, 1);
      chk("t3_rej", coin_reject, 1);
      chk("t3_credit_hold", credit, 50);
      step(1, 4, 0, 0, 1);
      chk("t3_item", item, 4);
      chk("t3_chg", change, 25);
      step(0, 0, 0, 0, 1);

      step(1, 3, 0, 0, 1);
      step(0, 0, 2, 0, 1);
      step(0, 0, 1, 1, 1);
      chk("t4_chg", change, 10);
      chk("t4_cv", change_vld, 1);
      chk("t4_rej", coin_reject, 1);
      chk("t4_disp", dispense, 0);
      step(0, 0, 0, 0, 1);

      step(0, 0, 2, 0, 1);
      step(0, 0, 0, 0, 0);
      chk("t5_credit", credit, 0);
      chk("t5_cv", change_vld, 0);
      step(0, 0, 0, 1, 1);
      chk("t5_cancel0", change_vld, 0);

      step(1, 0, 2, 0, 1);
      step(1, 5, 0, 0, 1);
      chk("t6_badsel", dispense, 0);
      chk("t6_credit", credit, 10);
      step(1, 1, 0, 0, 1);
      chk("t6_item", item, 1);
      step(0, 0, 1, 1, 1);
      chk("t6_vend_rej", coin_reject, 1);
      chk("t6_vend_nocancel", change_vld, 0);
      step(1, 4, 2, 0, 1);
      step(1, 1, 0, 0, 1);
      chk("t6_resel", item, 1);
      step(0, 0, 0, 0, 1);

      for (int k = 0; k < 300; k++) begin
`ifdef VM_STOCK_EN
         restock = ($urandom_range(0, 19) == 0);
`endif
         step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
      end
      step(0, 0, 0, 0, 0);

`ifdef VM_STOCK_EN
      restock = 1'b1;
      step(0, 0, 0, 0, 1);
      restock = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(1, 1, 2, 0, 1);
         step(0, 0, 0, 0, 1);
      end
      chk("st_sold", sold_out[0], 1);
      step(1, 1, 2, 0, 1);
      chk("st_ignored", dispense, 0);
      chk("st_credit", credit, 10);
      step(0, 0, 0, 1, 1);
      restock = 1'b1;
      step(0, 0, 0, 0, 1);
      restock = 1'b0;
      chk("st_restock", sold_out[0], 0);
      step(0, 0, 0, 0, 1);
`endif

      @(negedge clk);
      armed = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
